// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the parametrised multi-port register file.
// Used by reg_file_mp and its clear controller.
package reg_file_pkg;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  localparam int RF_DATA_WIDTH_DEF = 32;
  localparam int RF_ADDR_WIDTH_DEF = 5;

  // Bit offset of port 'port' inside a packed bus of 'width'-bit fields.
  function automatic int field_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/rf_clear_ctrl.sv
// Clear sequencer: walks every entry writing zero after reset or a clear
// request, then reports ready; flags writes that arrive while not accepting.
module rf_clear_ctrl
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr_req,
  input  logic                  wr_en,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  ready,
  output logic                  wr_ignored
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  rf_state_e             state_r;
  logic [ADDR_WIDTH-1:0] cnt_r;
  logic                  wr_ignored_r;

  // Sequencer state, clear counter and dropped-write flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= RF_CLEAR;
      cnt_r        <= {ADDR_WIDTH{1'b0}};
      wr_ignored_r <= 1'b0;
    end else begin
      case (state_r)
        RF_CLEAR: begin
          wr_ignored_r <= wr_en;
          if (cnt_r == LAST_ADDR) begin
            state_r <= RF_READY;
          end else begin
            cnt_r <= cnt_r + ADDR_WIDTH'(1);
          end
        end
        RF_READY: begin
          // A clear request wins over a same-cycle write.
          wr_ignored_r <= wr_en & clr_req;
          if (clr_req) begin
            state_r <= RF_CLEAR;
            cnt_r   <= {ADDR_WIDTH{1'b0}};
          end
        end
        default: begin
          state_r      <= RF_CLEAR;
          cnt_r        <= {ADDR_WIDTH{1'b0}};
          wr_ignored_r <= 1'b0;
        end
      endcase
    end
  end

  assign ready      = (state_r == RF_READY);
  assign clr_we     = (state_r == RF_CLEAR) & ~reset;
  assign clr_addr   = cnt_r;
  assign wr_ignored = wr_ignored_r;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised 1W/NUM_RD-read register file with hardware clear and x0 tied to zero.
// Define RF_BYPASS_EN to forward same-cycle write data onto matching read ports.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH_DEF,
  parameter int NUM_RD     = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr_req,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic                         ready,
  output logic                         wr_ignored
);

  localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic                  clr_we_s;
  logic [ADDR_WIDTH-1:0] clr_addr_s;
  logic                  wr_fire_s;
  logic                  fwd_en_s;

  rf_clear_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clear_ctrl (
    .clk       (clk),
    .reset     (reset),
    .clr_req   (clr_req),
    .wr_en     (wr_en),
    .clr_we    (clr_we_s),
    .clr_addr  (clr_addr_s),
    .ready     (ready),
    .wr_ignored(wr_ignored)
  );

  assign wr_fire_s = ready & wr_en & ~clr_req & ~reset & (wr_addr != ZERO_ADDR);

`ifdef RF_BYPASS_EN
  assign fwd_en_s = ready & wr_en & (wr_addr != ZERO_ADDR);
`else
  assign fwd_en_s = 1'b0;
`endif

  // Array write port: the clear sequencer owns it while clearing.
  always_ff @(posedge clk) begin
    if (clr_we_s) begin
      mem_r[clr_addr_s] <= {DATA_WIDTH{1'b0}};
    end else if (wr_fire_s) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    localparam int A_LSB = field_lsb(i, ADDR_WIDTH);
    localparam int D_LSB = field_lsb(i, DATA_WIDTH);

    logic [ADDR_WIDTH-1:0] addr_s;
    logic [DATA_WIDTH-1:0] data_s;

    assign addr_s = rd_addr[A_LSB +: ADDR_WIDTH];

    // Read mux: zero for x0 or while clearing, else forwarded or stored data.
    always_comb begin
      data_s = {DATA_WIDTH{1'b0}};
      if (!ready || addr_s == ZERO_ADDR) begin
        data_s = {DATA_WIDTH{1'b0}};
      end else if (fwd_en_s && addr_s == wr_addr) begin
        data_s = wr_data;
      end else begin
        data_s = mem_r[addr_s];
      end
    end

    assign rd_data[D_LSB +: DATA_WIDTH] = data_s;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp: default 32x32/2R build plus
// a small 8x16/3R instance.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        reset   = 1'b1;
  logic        clr_req = 1'b0;
  logic        wr_en   = 1'b0;
  logic [4:0]  wr_addr = 5'd0;
  logic [31:0] wr_data = 32'd0;
  logic [9:0]  rd_addr = 10'd0;
  logic [63:0] rd_data;
  logic        ready;
  logic        wr_ignored;

  // Small instance: 8 entries, 16 bits, 3 read ports
  logic        s_reset   = 1'b1;
  logic        s_clr_req = 1'b0;
  logic        s_wr_en   = 1'b0;
  logic [2:0]  s_wr_addr = 3'd0;
  logic [15:0] s_wr_data = 16'd0;
  logic [8:0]  s_rd_addr = 9'd0;
  logic [47:0] s_rd_data;
  logic        s_ready;
  logic        s_wr_ignored;

  int total = 0;
  int bad   = 0;
  int n;

  reg_file_mp u_dut (
    .clk       (clk),
    .reset     (reset),
    .clr_req   (clr_req),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .ready     (ready),
    .wr_ignored(wr_ignored)
  );

  reg_file_mp #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(3),
    .NUM_RD    (3)
  ) u_small (
    .clk       (clk),
    .reset     (s_reset),
    .clr_req   (s_clr_req),
    .wr_en     (s_wr_en),
    .wr_addr   (s_wr_addr),
    .wr_data   (s_wr_data),
    .rd_addr   (s_rd_addr),
    .rd_data   (s_rd_data),
    .ready     (s_ready),
    .wr_ignored(s_wr_ignored)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic wait_ready(input int budget, output int cycles);
    cycles = 0;
    while (!ready && cycles < budget) begin
      step();
      cycles++;
    end
  endtask

  initial begin
    // 1: reset, 32-cycle clear, everything reads zero
    step();
    step();
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_wr_ignored", {31'd0, wr_ignored}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      check("clr_busy", {31'd0, ready}, 32'd0);
      step();
    end
    check("clr_done", {31'd0, ready}, 32'd1);
    for (int a = 1; a < 32; a++) begin
      rd(5'(a), 5'(31 - a));
      check("init_p0", rd_data[31:0], 32'd0);
      check("init_p1", rd_data[63:32], 32'd0);
    end

    // 2: basic write/read and x0 hardwiring
    write(5'd5, 32'hDEADBEEF);
    rd(5'd5, 5'd0);
    check("x5_p0", rd_data[31:0], 32'hDEADBEEF);
    check("x0_p1", rd_data[63:32], 32'd0);
    write(5'd0, 32'h00001234);
    rd(5'd0, 5'd5);
    check("x0_after_wr", rd_data[31:0], 32'd0);
    check("x5_p1", rd_data[63:32], 32'hDEADBEEF);
    check("no_ignore", {31'd0, wr_ignored}, 32'd0);

    // 3: write during clear is dropped and flagged
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd(5'd5, 5'd5);
    check("clear_reads_zero", rd_data[31:0], 32'd0);
    for (int i = 0; i < 10; i++) step();
    write(5'd7, 32'hA5A5A5A5);
    check("ign_set", {31'd0, wr_ignored}, 32'd1);
    step();
    check("ign_pulse", {31'd0, wr_ignored}, 32'd0);
    wait_ready(40, n);
    check("ready_after_rst", {31'd0, ready}, 32'd1);
    rd(5'd7, 5'd5);
    check("x7_dropped", rd_data[31:0], 32'd0);
    check("x5_cleared", rd_data[63:32], 32'd0);

    // 4: clr_req with simultaneous write
    write(5'd3, 32'h00000011);
    write(5'd4, 32'h00000022);
    rd(5'd3, 5'd4);
    check("x3_set", rd_data[31:0], 32'h00000011);
    check("x4_set", rd_data[63:32], 32'h00000022);
    clr_req = 1'b1;
    write(5'd9, 32'h00000099);
    clr_req = 1'b0;
    check("clr_ready_low", {31'd0, ready}, 32'd0);
    check("clr_ign", {31'd0, wr_ignored}, 32'd1);
    wait_ready(100, n);
    check("clr_len", n, 32'd32);
    rd(5'd3, 5'd4);
    check("x3_clr", rd_data[31:0], 32'd0);
    check("x4_clr", rd_data[63:32], 32'd0);
    rd(5'd9, 5'd9);
    check("x9_clr", rd_data[31:0], 32'd0);

    // 5: same-cycle write and read
    write(5'd12, 32'h11111111);
    wr_en   = 1'b1;
    wr_addr = 5'd12;
    wr_data = 32'hCAFE0001;
    rd(5'd12, 5'd3);
`ifdef RF_BYPASS_EN
    check("bypass_same", rd_data[31:0], 32'hCAFE0001);
`else
    check("nobypass_old", rd_data[31:0], 32'h11111111);
`endif
    check("bypass_other", rd_data[63:32], 32'd0);
    step();
    wr_en = 1'b0;
    #1;
    check("x12_next", rd_data[31:0], 32'hCAFE0001);

    // 6: small configuration, 8-cycle clear, three ports
    s_reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("s_clr_busy", {31'd0, s_ready}, 32'd0);
      step();
    end
    check("s_clr_done", {31'd0, s_ready}, 32'd1);
    s_wr_en   = 1'b1;
    s_wr_addr = 3'd6;
    s_wr_data = 16'hBEEF;
    step();
    s_wr_en   = 1'b0;
    s_rd_addr = {3'd6, 3'd6, 3'd6};
    #1;
    check("s_p0", {16'd0, s_rd_data[15:0]}, 32'h0000BEEF);
    check("s_p1", {16'd0, s_rd_data[31:16]}, 32'h0000BEEF);
    check("s_p2", {16'd0, s_rd_data[47:32]}, 32'h0000BEEF);
    s_rd_addr = {3'd0, 3'd5, 3'd6};
    #1;
    check("s_mix_p0", {16'd0, s_rd_data[15:0]}, 32'h0000BEEF);
    check("s_mix_p1", {16'd0, s_rd_data[31:16]}, 32'd0);
    check("s_mix_p2", {16'd0, s_rd_data[47:32]}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
